// File: rtl/ascon_fsm_if.sv
// Block-level handshake between the ASCON controller, its data source and the host.
interface ascon_fsm_if;
  logic start_i;
  logic data_valid_i;
  logic data_ack_o;
  logic cipher_valid_o;
  logic busy_o;
  logic done_o;

  modport master (
    output start_i, data_valid_i,
    input  data_ack_o, cipher_valid_o, busy_o, done_o
  );

  modport slave (
    input  start_i, data_valid_i,
    output data_ack_o, cipher_valid_o, busy_o, done_o
  );
endinterface

// File: rtl/ascon_fsm.sv
// ASCON-128 AEAD encryption sequencer: one permutation round per clock across
// initialisation, AD absorption, plaintext encryption and finalisation.
module ascon_fsm #(
  parameter int AD_BLOCKS = 1,
  parameter int PT_BLOCKS = 4
) (
  input  logic        clock_i,
  input  logic        resetb_i,
  ascon_fsm_if.slave  bus,
  output logic        select_o,
  output logic        enable_o,
  output logic        xor_data_begin_o,
  output logic        xor_key_begin_o,
  output logic        xor_key_end_o,
  output logic        xor_ext_end_o,
  output logic        enable_cipher_o,
  output logic        enable_tag_o,
  output logic [3:0]  round_o
);
  localparam int BLK_W = 16;
  localparam logic [BLK_W-1:0] AD_LAST = BLK_W'((AD_BLOCKS > 0) ? AD_BLOCKS - 1 : 0);
  localparam logic [BLK_W-1:0] PT_LAST = BLK_W'(PT_BLOCKS - 1);

  typedef enum logic [2:0] {IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL, DONE} state_t;

  state_t           state;
  logic [3:0]       rnd;
  logic [BLK_W-1:0] blk;
  logic             cipher_valid;
  logic             accept;
  logic             pt_last;

  assign accept  = bus.data_valid_i && ((state == WAIT_AD) || (state == WAIT_PT));
  assign pt_last = (state == WAIT_PT) && (blk == PT_LAST);

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state        <= IDLE;
      rnd          <= 4'd0;
      blk          <= '0;
      cipher_valid <= 1'b0;
    end else begin
      cipher_valid <= accept && (state == WAIT_PT);
      case (state)
        IDLE: if (bus.start_i) begin
          state <= INIT;
          rnd   <= 4'd0;
          blk   <= '0;
        end
        INIT: if (rnd == 4'd11) begin
          state <= (AD_BLOCKS == 0) ? WAIT_PT : WAIT_AD;
          rnd   <= 4'd0;
          blk   <= '0;
        end else begin
          rnd <= rnd + 4'd1;
        end
        WAIT_AD: if (bus.data_valid_i) begin
          state <= AD;
          rnd   <= 4'd7;
        end
        AD: if (rnd == 4'd11) begin
          rnd <= 4'd0;
          if (blk == AD_LAST) begin
            state <= WAIT_PT;
            blk   <= '0;
          end else begin
            state <= WAIT_AD;
            blk   <= blk + BLK_W'(1);
          end
        end else begin
          rnd <= rnd + 4'd1;
        end
        // The last PT block is merged with the first finalisation round.
        WAIT_PT: if (bus.data_valid_i) begin
          if (blk == PT_LAST) begin
            state <= FINAL;
            rnd   <= 4'd1;
            blk   <= '0;
          end else begin
            state <= PT;
            rnd   <= 4'd7;
          end
        end
        PT: if (rnd == 4'd11) begin
          state <= WAIT_PT;
          rnd   <= 4'd0;
          blk   <= blk + BLK_W'(1);
        end else begin
          rnd <= rnd + 4'd1;
        end
        FINAL: if (rnd == 4'd11) begin
          state <= DONE;
          rnd   <= 4'd0;
        end else begin
          rnd <= rnd + 4'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode from the state registers; WAIT states add the Mealy accept path.
  always_comb begin
    select_o         = 1'b0;
    enable_o         = 1'b0;
    xor_data_begin_o = 1'b0;
    xor_key_begin_o  = 1'b0;
    xor_key_end_o    = 1'b0;
    xor_ext_end_o    = 1'b0;
    enable_cipher_o  = 1'b0;
    enable_tag_o     = 1'b0;
    round_o          = 4'd0;
    bus.data_ack_o   = 1'b0;
    bus.done_o       = 1'b0;
    bus.busy_o       = (state != IDLE);
    case (state)
      INIT: begin
        enable_o      = 1'b1;
        round_o       = rnd;
        select_o      = (rnd == 4'd0);
        xor_key_end_o = (rnd == 4'd11);
        xor_ext_end_o = (rnd == 4'd11) && (AD_BLOCKS == 0);
      end
      WAIT_AD, WAIT_PT: if (accept) begin
        bus.data_ack_o   = 1'b1;
        xor_data_begin_o = 1'b1;
        enable_o         = 1'b1;
        enable_cipher_o  = (state == WAIT_PT);
        xor_key_begin_o  = pt_last;
        round_o          = pt_last ? 4'd0 : 4'd6;
      end
      AD: begin
        enable_o      = 1'b1;
        round_o       = rnd;
        xor_ext_end_o = (rnd == 4'd11) && (blk == AD_LAST);
      end
      PT: begin
        enable_o = 1'b1;
        round_o  = rnd;
      end
      FINAL: begin
        enable_o      = 1'b1;
        round_o       = rnd;
        xor_key_end_o = (rnd == 4'd11);
        enable_tag_o  = (rnd == 4'd11);
      end
      DONE:    bus.done_o = 1'b1;
      default: ;
    endcase
  end

  assign bus.cipher_valid_o = cipher_valid;
endmodule

// File: tb/tb_ascon_fsm.sv
// Directed bench for ascon_fsm: cycle-exact strobe traces against hand-derived schedules.
module tb_ascon_fsm;
  logic clk = 1'b0;
  logic resetb = 1'b0;
  logic start_r = 1'b0;
  logic valid_r = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cnt;

  always #5 clk = ~clk;

  ascon_fsm_if ifc0 ();
  ascon_fsm_if ifc1 ();
  ascon_fsm_if ifc2 ();
  assign ifc0.start_i = start_r;
  assign ifc1.start_i = start_r;
  assign ifc2.start_i = start_r;
  assign ifc0.data_valid_i = valid_r;
  assign ifc1.data_valid_i = valid_r;
  assign ifc2.data_valid_i = valid_r;

  logic       sel0, en0, xdb0, xkb0, xke0, xee0, enc0, ent0;
  logic       sel1, en1, xdb1, xkb1, xke1, xee1, enc1, ent1;
  logic       sel2, en2, xdb2, xkb2, xke2, xee2, enc2, ent2;
  logic [3:0] rnd0, rnd1, rnd2;
  logic [15:0] obs0, obs1, obs2;

  ascon_fsm dut0 (
    .clock_i(clk), .resetb_i(resetb), .bus(ifc0.slave),
    .select_o(sel0), .enable_o(en0), .xor_data_begin_o(xdb0), .xor_key_begin_o(xkb0),
    .xor_key_end_o(xke0), .xor_ext_end_o(xee0), .enable_cipher_o(enc0),
    .enable_tag_o(ent0), .round_o(rnd0));

  ascon_fsm #(.AD_BLOCKS(0)) dut1 (
    .clock_i(clk), .resetb_i(resetb), .bus(ifc1.slave),
    .select_o(sel1), .enable_o(en1), .xor_data_begin_o(xdb1), .xor_key_begin_o(xkb1),
    .xor_key_end_o(xke1), .xor_ext_end_o(xee1), .enable_cipher_o(enc1),
    .enable_tag_o(ent1), .round_o(rnd1));

  ascon_fsm #(.AD_BLOCKS(2), .PT_BLOCKS(1)) dut2 (
    .clock_i(clk), .resetb_i(resetb), .bus(ifc2.slave),
    .select_o(sel2), .enable_o(en2), .xor_data_begin_o(xdb2), .xor_key_begin_o(xkb2),
    .xor_key_end_o(xke2), .xor_ext_end_o(xee2), .enable_cipher_o(enc2),
    .enable_tag_o(ent2), .round_o(rnd2));

  // Packing: {round[3:0], ack, select, enable, xdb, xkb, xke, xee, enc, ent, cv, busy, done}
  assign obs0 = {rnd0, ifc0.data_ack_o, sel0, en0, xdb0, xkb0, xke0, xee0, enc0, ent0,
                 ifc0.cipher_valid_o, ifc0.busy_o, ifc0.done_o};
  assign obs1 = {rnd1, ifc1.data_ack_o, sel1, en1, xdb1, xkb1, xke1, xee1, enc1, ent1,
                 ifc1.cipher_valid_o, ifc1.busy_o, ifc1.done_o};
  assign obs2 = {rnd2, ifc2.data_ack_o, sel2, en2, xdb2, xkb2, xke2, xee2, enc2, ent2,
                 ifc2.cipher_valid_o, ifc2.busy_o, ifc2.done_o};

  // Default message schedule, k cycles after start_i was sampled (k=0 means idle).
  function automatic logic [15:0] exp_nom(int k);
    logic [3:0] r;
    logic ack, sel, en, xdb, xkb, xke, xee, enc, ent, cv, bsy, dn;
    r   = 4'd0;
    bsy = (k >= 1 && k <= 49);
    en  = (k >= 1 && k <= 48);
    sel = (k == 1);
    ack = (k == 13 || k == 19 || k == 25 || k == 31 || k == 37);
    xdb = ack;
    xkb = (k == 37);
    xke = (k == 12 || k == 48);
    xee = (k == 18);
    enc = (k == 19 || k == 25 || k == 31 || k == 37);
    ent = (k == 48);
    cv  = (k == 20 || k == 26 || k == 32 || k == 38);
    dn  = (k == 49);
    if (k >= 1 && k <= 12)       r = 4'(k - 1);
    else if (k == 37)            r = 4'd0;
    else if (k >= 38 && k <= 48) r = 4'(k - 37);
    else if (k >= 13 && k <= 36) r = 4'(((k - 13) % 6) + 6);
    return {r, ack, sel, en, xdb, xkb, xke, xee, enc, ent, cv, bsy, dn};
  endfunction

  // PT block 2 stalled for three cycles in WAIT_PT.
  function automatic logic [15:0] exp_stall(int k);
    if (k < 31) return exp_nom(k);
    if (k <= 33) return 16'h0002;
    return exp_nom(k - 3);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    checks++;
    assert (obs0 === 16'h0000) else begin failures++; $error("FAIL in_reset obs=%h exp=%h", obs0, 16'h0000); end
    repeat (2) @(posedge clk);
    #2 resetb = 1'b1;
    #1;
    checks++;
    assert (obs0 === 16'h0000) else begin failures++; $error("FAIL after_reset obs=%h exp=%h", obs0, 16'h0000); end

    // Nominal message on all three instances, data always valid.
    start_r = 1'b1;
    valid_r = 1'b1;
    #1;
    checks++;
    assert (obs0 === 16'h0000) else begin failures++; $error("FAIL idle_start obs=%h exp=%h", obs0, 16'h0000); end
    cnt = 0;
    for (int k = 1; k <= 55; k++) begin
      step();
      start_r = 1'b0;
      #1;
      checks++;
      assert (obs0 === exp_nom(k)) else begin failures++; $error("FAIL nom k=%0d obs=%h exp=%h", k, obs0, exp_nom(k)); end
      if (obs2[5]) cnt++;
      if (k == 12) begin
        checks++;
        assert (obs1[6:5] === 2'b11) else begin failures++; $error("FAIL ad0_init_end xke_xee=%b exp=11", obs1[6:5]); end
      end
      if (k == 13) begin
        checks++;
        assert ({obs1[11], obs1[4], obs1[15:12]} === {2'b11, 4'd6}) else begin
          failures++; $error("FAIL ad0_first_pt ack_enc_rnd=%b exp=%b", {obs1[11], obs1[4], obs1[15:12]}, {2'b11, 4'd6}); end
      end
      if (k == 14) begin
        checks++;
        assert ({obs1[15:12], obs1[2]} === {4'd7, 1'b1}) else begin
          failures++; $error("FAIL ad0_pt_round rnd_cv=%b exp=%b", {obs1[15:12], obs1[2]}, {4'd7, 1'b1}); end
      end
      if (k == 18) begin
        checks++;
        assert (obs2[5] === 1'b0) else begin failures++; $error("FAIL ad2_first_ext obs=%b exp=0", obs2[5]); end
      end
      if (k == 24) begin
        checks++;
        assert (obs2[5] === 1'b1) else begin failures++; $error("FAIL ad2_second_ext obs=%b exp=1", obs2[5]); end
      end
      if (k == 25) begin
        checks++;
        assert ({obs2[15:12], obs2[11], obs2[7], obs2[4]} === {4'd0, 3'b111}) else begin
          failures++; $error("FAIL pt1_last_accept obs=%b exp=%b", {obs2[15:12], obs2[11], obs2[7], obs2[4]}, {4'd0, 3'b111}); end
      end
      if (k == 37) begin
        checks++;
        assert (obs2[0] === 1'b1) else begin failures++; $error("FAIL pt1_done obs=%b exp=1", obs2[0]); end
      end
    end
    checks++;
    assert (cnt === 1) else begin failures++; $error("FAIL ad2_ext_count obs=%0d exp=1", cnt); end

    // Stall three cycles before PT block 2.
    start_r = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      step();
      start_r = 1'b0;
      valid_r = !(k >= 31 && k <= 33);
      #1;
      checks++;
      assert (obs0 === exp_stall(k)) else begin failures++; $error("FAIL stall k=%0d obs=%h exp=%h", k, obs0, exp_stall(k)); end
    end
    valid_r = 1'b1;

    // Asynchronous reset in FINAL at rnd=5.
    start_r = 1'b1;
    for (int k = 1; k <= 42; k++) begin
      step();
      start_r = 1'b0;
      #1;
      checks++;
      assert (obs0 === exp_nom(k)) else begin failures++; $error("FAIL pre_reset k=%0d obs=%h exp=%h", k, obs0, exp_nom(k)); end
    end
    resetb = 1'b0;
    #1;
    checks++;
    assert ({obs0, obs1, obs2} === 48'h0) else begin
      failures++; $error("FAIL async_reset obs=%h exp=%h", {obs0, obs1, obs2}, 48'h0); end
    step();
    #2 resetb = 1'b1;
    cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      #1;
      if (obs0 !== 16'h0000) cnt++;
    end
    checks++;
    assert (cnt === 0) else begin failures++; $error("FAIL post_reset_quiet nonzero_cycles=%0d exp=0", cnt); end

    // start_i held high across two back-to-back messages.
    start_r = 1'b1;
    cnt = 0;
    for (int k = 1; k <= 99; k++) begin
      step();
      #1;
      if (obs0[0]) cnt++;
      checks++;
      assert (obs0 === exp_nom(k % 50)) else begin
        failures++; $error("FAIL held_start k=%0d obs=%h exp=%h", k, obs0, exp_nom(k % 50)); end
    end
    start_r = 1'b0;
    checks++;
    assert (cnt === 2) else begin failures++; $error("FAIL held_done_count obs=%0d exp=2", cnt); end
    step();
    step();
    checks++;
    assert (obs0 === 16'h0000) else begin failures++; $error("FAIL final_idle obs=%h exp=%h", obs0, 16'h0000); end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
